activation_feeder: RTL and testbench

- Source-side companion to the convolution/ReLU/max-pool pipeline. Buffers one n×n activation map and one k×k kernel loaded by the host.
- On `start`, streams activations one per cycle, row-major, with `ce` qualification into the pipeline's `activation`/`ce`/`weight` inputs.
- Drives flush cycles until the pipeline's `end_op` returns, then reports completion.
- Closes the loop: host load -> stream -> drain -> done.

---
 rtl/activation_feeder.sv | 187 ++++++++++++++++++
 tb/tb_activation_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_feeder.sv
// Source-side feeder: buffers an n*n activation map and a k*k kernel, streams the map row-major
// with ce qualification, then flushes until end_op. Optional frame counter: FEEDER_PERF_CNT_EN.
module activation_feeder #(
    parameter int N         = 16,
    parameter int n         = 4,
    parameter int k         = 3,
    parameter int DRAIN_MAX = 64
) (
    input  logic                   clk,
    input  logic                   global_rst,
    input  logic                   wr_en,
    input  logic [$clog2(n*n)-1:0] wr_addr,
    input  logic [N-1:0]           wr_data,
    input  logic                   w_wr_en,
    input  logic [$clog2(k*k)-1:0] w_idx,
    input  logic [N-1:0]           w_data,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   end_op,
    output logic [N-1:0]           activation,
    output logic [k*k*N-1:0]       weight,
    output logic                   ce,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic [15:0]            cycle_cnt
);

    localparam int DEPTH = n * n;
    localparam int AW    = $clog2(DEPTH);
    localparam int KK    = k * k;
    localparam int KW    = $clog2(KK);
    localparam int DW    = $clog2(DRAIN_MAX + 1);

    localparam logic [AW-1:0] LAST_PIX    = AW'(DEPTH - 1);
    localparam logic [DW-1:0] DRAIN_LIMIT = DW'(DRAIN_MAX);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   pix, pix_d;
    logic [DW-1:0]   drain_cnt, drain_d;
    logic [N-1:0]    act_d;
    logic            ce_d, busy_d, err_d;
    logic            addr_ok, idx_ok;
    logic [N-1:0]    mem [DEPTH];

    // Range checks only exist when the address space is larger than the storage.
    generate
        if (DEPTH == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (wr_addr < AW'(DEPTH));
        end
        if (KK == (1 << KW)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = (w_idx < KW'(KK));
        end
    endgenerate

    // NOTE: the buffer has no reset; its contents after reset are don't-care, and leaving it
    // out of the reset tree lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE) && addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        pix_d   = pix;
        drain_d = drain_cnt;
        act_d   = activation;
        ce_d    = 1'b0;
        busy_d  = busy;
        err_d   = err_timeout;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    pix_d   = '0;
                    drain_d = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            STREAM: begin
                if (!stall) begin
                    ce_d  = 1'b1;
                    act_d = mem[pix];
                    if (pix == LAST_PIX) begin
                        pix_d   = '0;
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        pix_d = pix + AW'(1);
                    end
                end
            end
            DRAIN: begin
                // end_op outranks the timeout when both land on the same edge.
                if (end_op) begin
                    state_d = DONE;
                end else if (drain_cnt == DRAIN_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!stall) begin
                    ce_d    = 1'b1;
                    act_d   = '0;
                    drain_d = drain_cnt + DW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together
    // from the values sampled at the edge.
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            pix         <= '0;
            drain_cnt   <= '0;
            activation  <= '0;
            ce          <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            pix         <= pix_d;
            drain_cnt   <= drain_d;
            activation  <= act_d;
            ce          <= ce_d;
            busy        <= busy_d;
            err_timeout <= err_d;
        end
    end

    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            weight <= '0;
        end else if (w_wr_en && (state == IDLE) && idx_ok) begin
            weight[int'(w_idx)*N +: N] <= w_data;
        end
    end

    assign done = (state == DONE);

`ifdef FEEDER_PERF_CNT_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            perf_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            perf_cnt <= '0;
        end else if (busy && (perf_cnt != 16'hFFFF)) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end

    assign cycle_cnt = perf_cnt;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_activation_feeder.sv
// Directed bench for activation_feeder: load, stream, stall bubbles, drain timeout,
// writes while busy, mid-frame reset, and end_op during streaming.
module tb_activation_feeder;

    localparam int N  = 16;
    localparam int NN = 4;
    localparam int K  = 3;
    localparam int DM = 64;
    localparam logic [K*K*N-1:0] W_ALL = {9{16'h1000}};

    logic                 clk = 1'b0;
    logic                 global_rst;
    logic                 wr_en, w_wr_en, start, stall, end_op;
    logic [3:0]           wr_addr, w_idx;
    logic [N-1:0]         wr_data, w_data;
    logic [N-1:0]         activation;
    logic [K*K*N-1:0]     weight;
    logic                 ce, busy, done, err_timeout;
    logic [15:0]          cycle_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] acts[$];
    int done_cnt = 0;
    int ab, db;

    activation_feeder #(.N(N), .n(NN), .k(K), .DRAIN_MAX(DM)) dut (
        .clk         (clk),
        .global_rst  (global_rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .w_wr_en     (w_wr_en),
        .w_idx       (w_idx),
        .w_data      (w_data),
        .start       (start),
        .stall       (stall),
        .end_op      (end_op),
        .activation  (activation),
        .weight      (weight),
        .ce          (ce),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Passive capture of every ce-qualified word and every done pulse.
    always @(negedge clk) begin
        if (ce) acts.push_back(activation);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic mem_wr(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycles(1);
        wr_en = 1'b0;
    endtask

    task automatic k_wr(input logic [3:0] i, input logic [15:0] d);
        w_wr_en = 1'b1; w_idx = i; w_data = d;
        cycles(1);
        w_wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) mem_wr(4'(i), 16'(i * 256));
        for (int i = 0; i < 9; i++) k_wr(4'(i), 16'h1000);
    endtask

    // Raises start for one edge; returns at the falling edge after it was accepted.
    task automatic pulse_start(output int a_base, output int d_base);
        a_base = acts.size();
        d_base = done_cnt;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int base, input int n_flush);
        logic [15:0] obs, exp;
        check({tag, "_count"}, 160'(acts.size() - base), 160'(16 + n_flush));
        for (int i = 0; i < 16 + n_flush; i++) begin
            exp = (i < 16) ? 16'(i * 256) : 16'h0000;
            obs = (base + i < acts.size()) ? acts[base + i] : 'x;
            check($sformatf("%s_w%0d", tag, i), 160'(obs), 160'(exp));
        end
    endtask

    initial begin
        global_rst = 1'b0;
        wr_en = 1'b0; w_wr_en = 1'b0; start = 1'b0; stall = 1'b0; end_op = 1'b0;
        wr_addr = '0; w_idx = '0; wr_data = '0; w_data = '0;
        #12;
        check("rst_ce", 160'(ce), 160'(0));
        check("rst_act", 160'(activation), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_done", 160'(done), 160'(0));
        check("rst_err", 160'(err_timeout), 160'(0));
        check("rst_weight", 160'(weight), 160'(0));
        check("rst_cycle_cnt", 160'(cycle_cnt), 160'(0));
        @(negedge clk);
        global_rst = 1'b1;
        cycles(1);

        load_all();
        check("kernel_load", 160'(weight), 160'(W_ALL));
        k_wr(4'd12, 16'hDEAD);
        check("kernel_idx_oob", 160'(weight), 160'(W_ALL));

        // Baseline frame, end_op three flush cycles into DRAIN.
        pulse_start(ab, db);
        check("f1_busy", 160'(busy), 160'(1));
        check("f1_ce_latency", 160'(ce), 160'(0));
        cycles(19);
        end_op = 1'b1;
        cycles(1);
        end_op = 1'b0;
        check("f1_done", 160'(done), 160'(1));
        check("f1_ce_off", 160'(ce), 160'(0));
        cycles(1);
        check("f1_done_pulse", 160'(done), 160'(0));
        check("f1_busy_low", 160'(busy), 160'(0));
        check("f1_err", 160'(err_timeout), 160'(0));
        check("f1_done_cnt", 160'(done_cnt - db), 160'(1));
        check_stream("f1", ab, 3);
`ifdef FEEDER_PERF_CNT_EN
        check("f1_cycle_cnt", 160'(cycle_cnt), 160'(21));
`else
        check("f1_cycle_cnt", 160'(cycle_cnt), 160'(0));
`endif

        // Four stall cycles after pixel 4.
        pulse_start(ab, db);
        cycles(5);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            check($sformatf("f2_bubble%0d_ce", i), 160'(ce), 160'(0));
            check($sformatf("f2_bubble%0d_act", i), 160'(activation), 160'(16'h0400));
        end
        stall = 1'b0;
        cycles(14);
        end_op = 1'b1;
        cycles(1);
        end_op = 1'b0;
        check("f2_done", 160'(done), 160'(1));
        cycles(1);
        check("f2_done_cnt", 160'(done_cnt - db), 160'(1));
        check_stream("f2", ab, 3);
`ifdef FEEDER_PERF_CNT_EN
        check("f2_cycle_cnt", 160'(cycle_cnt), 160'(25));
`else
        check("f2_cycle_cnt", 160'(cycle_cnt), 160'(0));
`endif

        // No end_op: drain runs out after DRAIN_MAX flush cycles.
        pulse_start(ab, db);
        cycles(80);
        check("f3_last_flush_ce", 160'(ce), 160'(1));
        check("f3_not_done_yet", 160'(done), 160'(0));
        cycles(1);
        check("f3_done", 160'(done), 160'(1));
        check("f3_err_set", 160'(err_timeout), 160'(1));
        check("f3_ce_off", 160'(ce), 160'(0));
        cycles(1);
        check("f3_err_sticky", 160'(err_timeout), 160'(1));
        check("f3_busy_low", 160'(busy), 160'(0));
        check("f3_done_cnt", 160'(done_cnt - db), 160'(1));
        check_stream("f3", ab, DM);

        // Host writes and a second start while busy must have no effect.
        pulse_start(ab, db);
        check("f4_err_cleared", 160'(err_timeout), 160'(0));
        check("f4_busy", 160'(busy), 160'(1));
        cycles(2);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        w_wr_en = 1'b1; w_idx = 4'd4; w_data = 16'hBEEF;
        start = 1'b1;
        cycles(1);
        wr_en = 1'b0; w_wr_en = 1'b0; start = 1'b0;
        check("f4_weight_kept", 160'(weight), 160'(W_ALL));
        cycles(16);
        end_op = 1'b1;
        cycles(1);
        end_op = 1'b0;
        check("f4_done", 160'(done), 160'(1));
        cycles(5);
        check("f4_single_frame_busy", 160'(busy), 160'(0));
        check("f4_done_cnt", 160'(done_cnt - db), 160'(1));
        check_stream("f4", ab, 3);

        // Reset while pixel 9 is on the bus.
        pulse_start(ab, db);
        cycles(10);
        check("f5_pix9_ce", 160'(ce), 160'(1));
        check("f5_pix9_act", 160'(activation), 160'(16'h0900));
        #2;
        global_rst = 1'b0;
        #1;
        check("f5_rst_ce", 160'(ce), 160'(0));
        check("f5_rst_busy", 160'(busy), 160'(0));
        check("f5_rst_act", 160'(activation), 160'(0));
        check("f5_rst_done", 160'(done), 160'(0));
        check("f5_rst_weight", 160'(weight), 160'(0));
        check("f5_words_before_rst", 160'(acts.size() - ab), 160'(10));
        check("f5_mem0_unwritten", 160'(acts[ab]), 160'(16'h0000));
        cycles(1);
        global_rst = 1'b1;
        cycles(3);
        check("f5_no_done", 160'(done_cnt - db), 160'(0));
        check("f5_idle_busy", 160'(busy), 160'(0));
        load_all();

        // end_op during STREAM is ignored; fresh frame restarts at pixel 0.
        pulse_start(ab, db);
        cycles(4);
        end_op = 1'b1;
        cycles(1);
        end_op = 1'b0;
        check("f6_stream_ce", 160'(ce), 160'(1));
        check("f6_stream_act", 160'(activation), 160'(16'h0400));
        check("f6_stream_busy", 160'(busy), 160'(1));
        cycles(14);
        end_op = 1'b1;
        cycles(1);
        end_op = 1'b0;
        check("f6_done", 160'(done), 160'(1));
        cycles(2);
        check("f6_done_cnt", 160'(done_cnt - db), 160'(1));
        check("f6_err", 160'(err_timeout), 160'(0));
        check_stream("f6", ab, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
